// File: rtl/idx_decoder_pkg.sv
// Shared constants and the reference decode for the buffered index-to-line decoder.
package idx_decoder_pkg;

  localparam int DEF_IDX_W = 3;
  localparam int DEF_DEPTH = 4;
  localparam int N_OUT     = 1 << DEF_IDX_W;
  localparam int LVL_W     = $clog2(DEF_DEPTH) + 1;

  // Active-low one-hot: only the line selected by idx is driven low.
  function automatic logic [N_OUT-1:0] onehot_n_of(input logic [DEF_IDX_W-1:0] idx);
    logic [N_OUT-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/idx_onehot_decoder_if.sv
// Handshake bundle for the decoder: index input stream, line-vector output stream, occupancy.
interface idx_onehot_decoder_if
  import idx_decoder_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int OUT_W = 1 << IDX_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] onehot_n;
  logic [CNT_W-1:0] level;

  modport master (
    output in_valid, in_idx, out_ready,
    input  in_ready, out_valid, onehot_n, level
  );

  modport slave (
    input  in_valid, in_idx, out_ready,
    output in_ready, out_valid, onehot_n, level
  );

endinterface

// File: rtl/idx_fifo.sv
// Index queue: circular storage with naturally wrapping pointers and an explicit level count.
module idx_fifo
  import idx_decoder_pkg::*;
#(
  parameter  int IDX_W = DEF_IDX_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [IDX_W-1:0] push_idx_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic [CNT_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  // The caller gates push_i with !full_o and pop_i with !empty_o.
  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] level_q, level_d;

  always_comb begin
    // NOTE: default first so every path assigns level_d and no latch is inferred.
    level_d = level_q;
    if (push_i && !pop_i) begin
      level_d = level_q + CNT_W'(1);
    end else if (pop_i && !push_i) begin
      level_d = level_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_idx_i;
  end

  assign head_idx_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign full_o     = (level_q == CNT_W'(DEPTH));
  assign empty_o    = (level_q == '0);

endmodule

// File: rtl/idx_onehot_decoder.sv
// Buffered index-to-line decoder: queues binary indices and presents each as a registered active-low one-hot vector.
module idx_onehot_decoder
  import idx_decoder_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                 clk,
  input logic                 rst_n,
  idx_onehot_decoder_if.slave bus
);

  localparam int OUT_W = 1 << IDX_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push, load;
  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] head_idx;
  logic [CNT_W-1:0] fifo_level;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] onehot_n_q, onehot_n_d;

  // in_ready depends on registered occupancy only, so a full queue refuses a push even while popping.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign load         = !fifo_empty && (!out_valid_q || bus.out_ready);

  idx_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_idx_i (bus.in_idx),
    .pop_i      (load),
    .head_idx_o (head_idx),
    .level_o    (fifo_level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    onehot_n_d  = onehot_n_q;
    if (load) begin
      out_valid_d = 1'b1;
      onehot_n_d  = ~(OUT_W'(1) << head_idx);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      onehot_n_d  = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      onehot_n_q  <= '1;
    end else begin
      out_valid_q <= out_valid_d;
      onehot_n_q  <= onehot_n_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.onehot_n  = onehot_n_q;
  assign bus.level     = fifo_level;

endmodule

// File: doc/idx_onehot_decoder.md
Name: idx_onehot_decoder

Overview:
Buffered index-to-line decoder. It is the receiving end for the priority encoder's binary index output. It accepts IDX_W-bit indices over a valid/ready handshake and queues them in a small FIFO. It then presents each one as an active-low one-hot line vector, matching the active-low convention of the team's 3-to-8 decoder, on a registered valid/ready output. It sits between an encoder/arbiter stage and per-line consumers that may stall.

Parameters:
IDX_W, 3, index width; N_OUT = 2**IDX_W output lines
DEPTH, 4, FIFO entries; power of 2, at least 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_idx is valid
in_ready  out  1  block can accept an index this cycle
in_idx  in  IDX_W  binary index to decode
out_valid  out  1  onehot_n holds a decoded index
out_ready  in  1  consumer accepts onehot_n this cycle
onehot_n  out  N_OUT  active-low one-hot; bit in_idx low, all others high
level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH (excludes output register)

Behaviour:
- Reset, asynchronous on rst_n low:
  - FIFO pointers and level cleared to 0.
  - out_valid = 0; onehot_n = all ones.
  - in_ready = 1 as soon as reset releases.
  - Asserting rst_n mid-stream discards all queued and presented entries immediately. No partial transfer survives.
- Accept: push occurs on the rising edge where in_valid && in_ready.
- in_ready = (level != DEPTH). It is derived from registered state only and never from out_ready. When full, no push occurs that cycle even if a pop happens simultaneously.
- Output register is loaded from the FIFO head on an edge where level != 0 and (!out_valid || out_ready).
- Output register contents after a load:
  - out_valid = 1.
  - onehot_n = ~(1 << head_idx).
- Consume: on an edge with out_valid && out_ready and no load, out_valid goes 0 and onehot_n goes all ones.
- While out_valid = 0, onehot_n is all ones. No line is ever asserted without valid.
- Hold: while out_valid && !out_ready, onehot_n and out_valid stay stable.
- Latency: an index pushed at edge k into an empty block appears on out_* after edge k+1, i.e. 2 edges from acceptance. There is no FIFO bypass.
- Throughput: 1 index/cycle sustained when out_ready is held high.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
- level updates:
  - +1 on push only.
  - −1 on load only.
  - Unchanged on both or neither.
- Ordering: strict FIFO. Duplicate indices are kept as separate entries.
- Every IDX_W-bit value is a legal index; there is no error path.

Decomposition:
- Package idx_decoder_pkg holds:
  - IDX_W and DEPTH defaults.
  - N_OUT and LVL_W constants.
  - A pure function onehot_n_of(idx) returning the active-low vector. The bench reuses it as its reference model.
- Sub-module idx_fifo is natural: storage, pointers, level, full/empty.
- Top level holds the handshake logic, the output register and the decode.

Test Plan:
1. Reset then single push of in_idx = 5 with out_ready = 1:
   - Edge after accept: level = 1.
   - Next edge: out_valid = 1, onehot_n = 8'b1101_1111.
   - Following edge: out_valid = 0, onehot_n = 8'hFF.
2. out_ready = 0, push indices 0,1,2,3,4:
   - First entry moves to the output register.
   - level reaches 4, then in_ready = 0.
   - A 6th push attempt is not accepted.
   - Release out_ready: outputs appear in order 0,1,2,3,4 with onehot_n FE, FD, FB, F7, EF.
3. out_ready = 1, continuous pushes of 7,6,…,0 on every cycle:
   - One output per cycle with no bubbles after the 2-edge fill.
   - level never exceeds 1.
4. Stall with out_valid = 1 and onehot_n = EF, out_ready toggled 0 for 3 cycles:
   - onehot_n and out_valid stay constant until out_ready = 1.
5. Three entries queued plus one presented, rst_n pulsed low mid-cycle:
   - Outputs go to out_valid = 0, onehot_n = FF, level = 0 asynchronously.
   - After release, a new push of 2 yields onehot_n = FB with no stale data.
6. FIFO full, out_ready = 1 and in_valid = 1 on the same cycle:
   - Pop occurs, push is refused, level = DEPTH−1.
   - Next cycle in_ready = 1 and the push is accepted.
